// File: rtl/rns_tc_pkg.sv
// Shared constants and helpers for the RNS thermometer-code datapath.
// The thermometer-to-binary decoder and the binary-to-thermometer encoder
// both take their widths and modulus from here so they cannot drift apart.
// The optional TC_BUBBLE_CORRECT_EN build macro is not used here; it only
// affects tc_decode.
package rns_tc_pkg;

  // Residue channel geometry: a thermometer code of TC_W bits represents
  // residues 0..TC_W, so the modulus is TC_W + 1.
  localparam int TC_W    = 6;
  localparam int BIN_W   = 3;
  localparam int MODULUS = TC_W + 1;

  // Error counter width and its saturation value.
  localparam int                    ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0]  ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

  // Classification of an incoming code.
  typedef enum logic {
    CODE_THERM  = 1'b0,
    CODE_BUBBLE = 1'b1
  } code_class_e;

  typedef logic [TC_W:1]    tc_code_t;
  typedef logic [BIN_W-1:0] residue_t;

  // Binary residue to LSB-first thermometer code (3 -> 000111).
  // Values at or above the modulus clamp to all ones.
  function automatic tc_code_t bin_to_tc(input residue_t value);
    tc_code_t code;
    code = '0;
    for (int i = 1; i <= TC_W; i++) begin
      code[i] = (i <= int'(value));
    end
    return code;
  endfunction

  // True when the code is a clean thermometer code (2**k - 1).
  function automatic logic is_thermometer(input tc_code_t code);
    logic [TC_W:0] ext;
    logic [TC_W:0] plus1;
    ext   = {1'b0, code};
    plus1 = ext + {{TC_W{1'b0}}, 1'b1};
    return ((ext & plus1) == '0);
  endfunction

endpackage

// File: rtl/tc_decode.sv
// Purely combinational thermometer-to-binary decoder.
// Build macro: TC_BUBBLE_CORRECT_EN -- when defined, a code with bubbles is
// decoded to its popcount (best-effort correction); when undefined it decodes
// to 0. Either way a bubbled code raises err.
module tc_decode #(
  parameter int TC_W  = 6,
  parameter int BIN_W = 3
) (
  input  logic [TC_W:1]    tc,
  output logic [BIN_W-1:0] value,
  output logic             err
);

  import rns_tc_pkg::*;

  logic [TC_W:0]    tc_ext;
  logic [TC_W:0]    tc_plus1;
  logic [BIN_W-1:0] ones;
  code_class_e      code_class;

  // A clean code has the form 0..01..1, so adding one carries through every
  // set bit and leaves no overlap with the original value.
  always_comb begin
    tc_ext     = {1'b0, tc};
    tc_plus1   = tc_ext + {{TC_W{1'b0}}, 1'b1};
    code_class = ((tc_ext & tc_plus1) == '0) ? CODE_THERM : CODE_BUBBLE;
  end

  // Count of set bits; for a clean code this is exactly the residue.
  always_comb begin
    ones = '0;
    for (int i = 1; i <= TC_W; i++) begin
      ones = ones + BIN_W'(tc[i]);
    end
  end

  // Select the reported value and the error flag.
  always_comb begin
    err = (code_class == CODE_BUBBLE);
    if (code_class == CODE_THERM) begin
      value = ones;
    end else begin
`ifdef TC_BUBBLE_CORRECT_EN
      value = ones;
`else
      value = '0;
`endif
    end
  end

endmodule

// File: rtl/tc_binary.sv
// Two-stage pipelined thermometer-to-binary converter with valid/ready
// handshakes on both sides and a saturating count of delivered error results.
// Stage 1 registers the raw code, stage 2 registers the decoded residue.
// Build macro: TC_BUBBLE_CORRECT_EN selects bubble correction in tc_decode.
// BIN_W must satisfy 2**BIN_W > TC_W so the largest residue fits.
module tc_binary #(
  parameter int TC_W  = rns_tc_pkg::TC_W,
  parameter int BIN_W = rns_tc_pkg::BIN_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [TC_W:1]                    in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [BIN_W-1:0]                 out,
  output logic                             err,
  output logic [rns_tc_pkg::ERR_CNT_W-1:0] err_count
);

  import rns_tc_pkg::*;

  logic             s1_valid;
  logic [TC_W:1]    s1_code;
  logic [BIN_W-1:0] dec_value;
  logic             dec_err;
  logic             s2_load;
  logic             out_fire;

  // Stage 2 can take new data when it is empty or its result leaves this
  // cycle; stage 1 drains into stage 2 under the same condition.
  always_comb begin
    s2_load  = !out_valid || out_ready;
    out_fire = out_valid && out_ready;
    in_ready = !rst && (!s1_valid || s2_load);
  end

  tc_decode #(
    .TC_W  (TC_W),
    .BIN_W (BIN_W)
  ) u_decode (
    .tc    (s1_code),
    .value (dec_value),
    .err   (dec_err)
  );

  // Stage 1: capture the raw code whenever there is room for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code <= in;
      end
    end
  end

  // Stage 2: register the decoded result; hold it while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      err       <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out <= dec_value;
        err <= dec_err;
      end
    end
  end

  // Count delivered error results, sticking at the maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (out_fire && err && (err_count != ERR_CNT_MAX)) begin
      err_count <= err_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_tc_binary.sv
// Self-checking bench for tc_binary: directed scenarios plus a randomized
// stream, checked against a queue-based reference of expected decodes.
module tb_tc_binary;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [6:1] tc_in;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out;
  logic       err;
  logic [7:0] err_count;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  int exp_val_q[$];
  int exp_err_q[$];
  int model_err_cnt = 0;

  int fire_count     = 0;
  int first_fire_cyc = -1;
  int last_fire_cyc  = -1;

  logic       hold_pend = 1'b0;
  logic [2:0] held_out;
  logic       held_err;

  tc_binary dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (tc_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .err       (err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic doCheck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference decode straight from the rules: clean codes are 2**k - 1.
  function automatic void refDecode(input int code, output int value, output int bad);
    bad   = 1;
    value = 0;
    for (int k = 0; k <= 6; k++) begin
      if (code == (1 << k) - 1) begin
        bad   = 0;
        value = k;
      end
    end
`ifdef TC_BUBBLE_CORRECT_EN
    if (bad != 0) value = $countones(code);
`endif
  endfunction

  function automatic int randValid();
    int k;
    k = $urandom_range(0, 6);
    return (1 << k) - 1;
  endfunction

  function automatic int randInvalid();
    int c, v, b;
    c = 5;
    for (int t = 0; t < 100; t++) begin
      c = $urandom_range(0, 63);
      refDecode(c, v, b);
      if (b != 0) break;
      c = 5;
    end
    return c;
  endfunction

  // Called at the falling edge: verifies hold behaviour and any output transfer.
  task automatic checkOutput();
    int ev, ee;
    if (hold_pend) begin
      doCheck("hold_valid", {31'b0, out_valid}, 32'd1);
      doCheck("hold_out", {29'b0, out}, {29'b0, held_out});
      doCheck("hold_err", {31'b0, err}, {31'b0, held_err});
    end
    if (out_valid && out_ready) begin
      if (first_fire_cyc < 0) first_fire_cyc = cyc;
      last_fire_cyc = cyc;
      fire_count++;
      if (exp_val_q.size() == 0) begin
        doCheck("spurious_out", 32'd1, 32'd0);
      end else begin
        ev = exp_val_q.pop_front();
        ee = exp_err_q.pop_front();
        doCheck("out", {29'b0, out}, ev);
        doCheck("err", {31'b0, err}, ee);
        doCheck("err_count_pre", {24'b0, err_count}, model_err_cnt);
        if (ee != 0 && model_err_cnt < 255) model_err_cnt++;
      end
    end
    hold_pend = out_valid && !out_ready;
    held_out  = out;
    held_err  = err;
  endtask

  // One clock cycle: drive inputs, check at the falling edge, update the model.
  task automatic applyStimulus(input logic r, input logic v, input int code,
                               input logic ordy, output logic accepted);
    int ev, ee;
    rst       = r;
    in_valid  = v;
    tc_in     = code[5:0];
    out_ready = ordy;
    @(negedge clk);
    accepted = 1'b0;
    if (r) begin
      doCheck("in_ready_in_reset", {31'b0, in_ready}, 32'd0);
    end else begin
      checkOutput();
      accepted = v && in_ready;
      if (accepted) begin
        refDecode(code, ev, ee);
        exp_val_q.push_back(ev);
        exp_err_q.push_back(ee);
      end
    end
    @(posedge clk);
    #1;
    if (r) begin
      exp_val_q.delete();
      exp_err_q.delete();
      model_err_cnt = 0;
      hold_pend     = 1'b0;
    end
    cyc++;
  endtask

  task automatic sendCode(input int code, input logic ordy, output int waited);
    logic acc;
    waited = 0;
    acc    = 1'b0;
    while (!acc && waited < 50) begin
      applyStimulus(1'b0, 1'b1, code, ordy, acc);
      waited++;
    end
    if (!acc) doCheck("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain(input int budget);
    logic acc;
    for (int i = 0; i < budget; i++) begin
      applyStimulus(1'b0, 1'b0, 0, 1'b1, acc);
      if (exp_val_q.size() == 0 && !out_valid) break;
    end
    doCheck("drain_empty", exp_val_q.size(), 32'd0);
  endtask

  initial begin
    logic acc;
    int   t_in, accepts, idx, guard, w;
    int   s2_codes[3];
    int   rnd_codes[1000];

    rst = 1'b1; in_valid = 1'b0; tc_in = '0; out_ready = 1'b0;

    // Reset: two cycles, then outputs must be cleared.
    applyStimulus(1'b1, 1'b0, 0, 1'b0, acc);
    applyStimulus(1'b1, 1'b0, 0, 1'b0, acc);
    doCheck("rst_out_valid", {31'b0, out_valid}, 32'd0);
    doCheck("rst_out", {29'b0, out}, 32'd0);
    doCheck("rst_err", {31'b0, err}, 32'd0);
    doCheck("rst_err_count", {24'b0, err_count}, 32'd0);
    rst = 1'b0;
    #1;
    doCheck("in_ready_after_rst", {31'b0, in_ready}, 32'd1);

    // Scenario 1: clean codes 0..6 back to back, latency and throughput.
    $display("[TB] scenario 1: clean stream");
    fire_count = 0; first_fire_cyc = -1;
    t_in = cyc;
    for (int k = 0; k <= 6; k++) begin
      applyStimulus(1'b0, 1'b1, (1 << k) - 1, 1'b1, acc);
      if (!acc) doCheck("s1_accept", 32'd0, 32'd1);
    end
    drain(20);
    doCheck("s1_latency", first_fire_cyc - t_in, 32'd2);
    doCheck("s1_count", fire_count, 32'd7);
    doCheck("s1_last", last_fire_cyc - t_in, 32'd8);

    // Scenario 2: backpressure fills the pipe after two accepts.
    $display("[TB] scenario 2: backpressure");
    s2_codes[0] = 7; s2_codes[1] = 1; s2_codes[2] = 63;
    idx = 0; accepts = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, s2_codes[idx], 1'b0, acc);
      if (acc) begin idx++; accepts++; end
    end
    doCheck("s2_accepts", accepts, 32'd2);
    doCheck("s2_in_ready_low", {31'b0, in_ready}, 32'd0);
    guard = 0;
    while (idx < 3 && guard < 20) begin
      applyStimulus(1'b0, 1'b1, s2_codes[idx], 1'b1, acc);
      if (acc) idx++;
      guard++;
    end
    doCheck("s2_all_sent", idx, 32'd3);
    drain(20);

    // Scenario 3: one bubbled code.
    $display("[TB] scenario 3: bubbled code");
    sendCode(6'b000101, 1'b1, w);
    drain(20);
    doCheck("s3_err_count", {24'b0, err_count}, 32'd1);

    // Scenario 4: saturation of the error counter.
    $display("[TB] scenario 4: error counter saturation");
    for (int i = 0; i < 260; i++) begin
      applyStimulus(1'b0, 1'b1, randInvalid(), 1'b1, acc);
      if (!acc) doCheck("s4_accept", 32'd0, 32'd1);
    end
    drain(20);
    doCheck("s4_err_count_sat", {24'b0, err_count}, 32'd255);
    doCheck("s4_model_sat", model_err_cnt, 32'd255);
    sendCode(randInvalid(), 1'b1, w);
    sendCode(randInvalid(), 1'b1, w);
    drain(20);
    doCheck("s4_err_count_stays", {24'b0, err_count}, 32'd255);

    // Scenario 5: reset with both stages full.
    $display("[TB] scenario 5: mid-flight reset");
    accepts = 0; guard = 0;
    while (accepts < 2 && guard < 10) begin
      applyStimulus(1'b0, 1'b1, randInvalid(), 1'b0, acc);
      if (acc) accepts++;
      guard++;
    end
    doCheck("s5_filled", accepts, 32'd2);
    applyStimulus(1'b1, 1'b0, 0, 1'b1, acc);
    applyStimulus(1'b0, 1'b0, 0, 1'b1, acc);
    doCheck("s5_out_valid", {31'b0, out_valid}, 32'd0);
    doCheck("s5_err_count", {24'b0, err_count}, 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 0, 1'b1, acc);
    doCheck("s5_no_stale", fire_count - (fire_count - 0), 32'd0);

    // Scenario 6: random handshake toggling with 1000 clean codes.
    $display("[TB] scenario 6: random stream");
    foreach (rnd_codes[i]) rnd_codes[i] = randValid();
    idx = 0; guard = 0;
    while (idx < 1000 && guard < 20000) begin
      applyStimulus(1'b0, ($urandom_range(0, 3) != 0), rnd_codes[idx],
                    ($urandom_range(0, 2) != 0), acc);
      if (acc) idx++;
      guard++;
    end
    doCheck("s6_all_sent", idx, 32'd1000);
    drain(100);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  // Absolute guard against a hung simulation.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
